alu_issue_seq: RTL and testbench

Operand/issue sequencer directly upstream of the ALU combinational core. It accepts one ALU operation at a time over a valid/ready handshake and decodes a 4-bit opcode into the core's 8-bit control word. It drives the core's operand, carry-in and output-enable inputs, then captures the core's result. Double-width (2*DATA_WIDTH) operations run as two sequential half passes, with the core's carry-out chained into the next pass's carry-in.

---
 rtl/alu_issue_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_issue_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// Issue sequencer for the ALU combinational core: decodes the opcode, runs one or
// two core passes (carry chained low->high for wide ops) and holds the result.
module alu_issue_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_op,
    input  logic                    in_wide,
    input  logic [2*DATA_WIDTH-1:0] in_a,
    input  logic [2*DATA_WIDTH-1:0] in_b,
    input  logic                    in_cin,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    output logic [7:0]              alu_ctrl,
    output logic                    alu_cin,
    output logic                    alu_out_en,
    input  logic [DATA_WIDTH-1:0]   alu_out,
    input  logic                    alu_cout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out_result,
    output logic                    out_cout,
    output logic [TAG_WIDTH-1:0]    out_tag,
    output logic                    out_illegal
);
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t              r_state;
    logic                r_wide;
    logic                r_is_arith;
    logic [DW-1:0]       r_a_hi;
    logic [DW-1:0]       r_b_hi;
    logic                r_carry;
    logic [TAG_WIDTH-1:0] r_tag;
    logic [2*DW-1:0]     r_result;
    logic                r_illegal;
    logic                r_out_valid;
    logic [DW-1:0]       r_alu_a;
    logic [DW-1:0]       r_alu_b;
    logic [7:0]          r_alu_ctrl;
    logic                r_alu_cin;
    logic                r_alu_en;

    logic [7:0]          w_ctrl;
    logic                w_legal;
    logic                w_is_arith;

    always_comb begin
        w_ctrl = 8'h00;
        case (in_op)
            4'd0:    w_ctrl = 8'h2C;
            4'd1:    w_ctrl = 8'hAC;
            4'd2:    w_ctrl = 8'h22;
            4'd3:    w_ctrl = 8'h32;
            4'd4:    w_ctrl = 8'h04;
            4'd5:    w_ctrl = 8'h44;
            4'd6:    w_ctrl = 8'h23;
            4'd7:    w_ctrl = 8'h33;
            4'd8:    w_ctrl = 8'h05;
            default: w_ctrl = 8'h00;
        endcase
    end

    // Wide SUB has no defined borrow chaining through the core, so it is rejected.
    assign w_legal    = (in_op <= 4'd8) && !(in_op == 4'd1 && in_wide);
    assign w_is_arith = (in_op <= 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wide      <= 1'b0;
            r_is_arith  <= 1'b0;
            r_a_hi      <= '0;
            r_b_hi      <= '0;
            r_carry     <= 1'b0;
            r_tag       <= '0;
            r_result    <= '0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_ctrl  <= 8'h00;
            r_alu_cin   <= 1'b0;
            r_alu_en    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_tag      <= in_tag;
                        r_result   <= '0;
                        r_carry    <= 1'b0;
                        r_wide     <= in_wide;
                        r_is_arith <= w_is_arith && w_legal;
                        r_a_hi     <= in_a[2*DW-1:DW];
                        r_b_hi     <= in_b[2*DW-1:DW];
                        if (!w_legal) begin
                            r_illegal   <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_illegal  <= 1'b0;
                            r_alu_a    <= in_a[DW-1:0];
                            r_alu_b    <= in_b[DW-1:0];
                            r_alu_ctrl <= w_ctrl;
                            r_alu_cin  <= w_is_arith & in_cin;
                            r_alu_en   <= 1'b1;
                            r_state    <= S_LO;
                        end
                    end
                end
                S_LO: begin
                    r_result[DW-1:0] <= alu_out;
                    r_carry          <= alu_cout;
                    if (r_wide) begin
                        // Only ADD reaches HI as an arithmetic op; chain its carry.
                        r_alu_a   <= r_a_hi;
                        r_alu_b   <= r_b_hi;
                        r_alu_cin <= r_is_arith & alu_cout;
                        r_state   <= S_HI;
                    end else begin
                        r_alu_a     <= '0;
                        r_alu_b     <= '0;
                        r_alu_ctrl  <= 8'h00;
                        r_alu_cin   <= 1'b0;
                        r_alu_en    <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_HI: begin
                    r_result[2*DW-1:DW] <= alu_out;
                    r_carry             <= alu_cout;
                    r_alu_a             <= '0;
                    r_alu_b             <= '0;
                    r_alu_ctrl          <= 8'h00;
                    r_alu_cin           <= 1'b0;
                    r_alu_en            <= 1'b0;
                    r_out_valid         <= 1'b1;
                    r_state             <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_ctrl    = r_alu_ctrl;
    assign alu_cin     = r_alu_cin;
    assign alu_out_en  = r_alu_en;
    assign out_valid   = r_out_valid;
    assign out_result  = r_result;
    // The core's carry is meaningless for logic ops, so it is masked here.
    assign out_cout    = r_carry & r_is_arith;
    assign out_tag     = r_tag;
    assign out_illegal = r_illegal;
endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural ALU core attached, directed plan steps plus
// random requests checked against whole-word reference arithmetic.
module tb_alu_issue_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic        in_wide;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic [3:0]  in_tag;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [7:0]  alu_ctrl;
    logic        alu_cin;
    logic        alu_out_en;
    logic [15:0] alu_out;
    logic        alu_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_cout;
    logic [3:0]  out_tag;
    logic        out_illegal;

    int total  = 0;
    int passed = 0;

    alu_issue_seq #(.DATA_WIDTH(16), .TAG_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_wide(in_wide),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_cin(alu_cin),
        .alu_out_en(alu_out_en), .alu_out(alu_out), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_cout(out_cout), .out_tag(out_tag), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Core model; logic ops drive a junk carry so the sequencer must mask it.
    function automatic logic [16:0] core_fn(input logic [7:0] c, input logic [15:0] a,
                                            input logic [15:0] b, input logic ci);
        logic [15:0] r;
        r = 16'h0;
        case (c)
            8'h2C: return {1'b0, a} + {1'b0, b} + 17'(ci);
            8'hAC: return {1'b0, a} + {1'b0, ~b} + 17'(ci);
            8'h22: r = a & b;
            8'h32: r = a | b;
            8'h04: r = a ^ b;
            8'h44: r = ~a;
            8'h23: r = ~(a & b);
            8'h33: r = ~(a | b);
            8'h05: r = ~(a ^ b);
            default: return 17'h0;
        endcase
        return {~^r, r};
    endfunction

    logic [16:0] core_s;
    always_comb begin
        core_s = 17'h0;
        if (alu_out_en) core_s = core_fn(alu_ctrl, alu_a, alu_b, alu_cin);
    end
    assign alu_out  = core_s[15:0];
    assign alu_cout = core_s[16];

    // Reference: {illegal, cout, result} from whole-word arithmetic.
    function automatic logic [33:0] ref_fn(input logic [3:0] op, input logic w,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic ci);
        logic [31:0] m;
        logic [32:0] s;
        logic [31:0] r;
        logic        co;
        m  = w ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        co = 1'b0;
        r  = 32'h0;
        if (op > 4'd8 || (op == 4'd1 && w)) return {1'b1, 1'b0, 32'h0};
        case (op)
            4'd0: begin
                s  = {1'b0, a & m} + {1'b0, b & m} + 33'(ci);
                r  = s[31:0] & m;
                co = w ? s[32] : s[16];
            end
            4'd1: begin
                s  = {1'b0, a & m} + {1'b0, ~b & m} + 33'(ci);
                r  = s[31:0] & m;
                co = s[16];
            end
            4'd2: r = (a & b) & m;
            4'd3: r = (a | b) & m;
            4'd4: r = (a ^ b) & m;
            4'd5: r = ~a & m;
            4'd6: r = ~(a & b) & m;
            4'd7: r = ~(a | b) & m;
            default: r = ~(a ^ b) & m;
        endcase
        return {1'b0, co, r};
    endfunction

    logic [7:0] ctrl_tbl [0:8] = '{8'h2C, 8'hAC, 8'h22, 8'h32, 8'h04, 8'h44, 8'h23, 8'h33, 8'h05};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic run_req(input logic [3:0] op, input logic w, input logic [31:0] a,
                           input logic [31:0] b, input logic ci, input logic [3:0] tag,
                           input int hold);
        logic [33:0] e;
        int          lat;
        int          k;
        logic        lo_c;
        e    = ref_fn(op, w, a, b, ci);
        lo_c = ((17'(a[15:0]) + 17'(b[15:0]) + 17'(ci)) >> 16) != 17'h0;
        k = 0;
        while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_op = op; in_wide = w; in_a = a; in_b = b; in_cin = ci; in_tag = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op = 4'($urandom); in_wide = 1'($urandom); in_a = $urandom; in_b = $urandom;
        in_cin = 1'($urandom); in_tag = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 8) begin
            if (lat == 1) begin
                chk("lo_en",   64'(alu_out_en), 64'd1);
                chk("lo_ctrl", 64'(alu_ctrl), 64'(ctrl_tbl[op]));
                chk("lo_ab",   64'({alu_a, alu_b}), 64'({a[15:0], b[15:0]}));
                chk("lo_cin",  64'(alu_cin), 64'((op <= 4'd1) ? ci : 1'b0));
            end else if (lat == 2) begin
                chk("hi_ctrl", 64'(alu_ctrl), 64'(ctrl_tbl[op]));
                chk("hi_ab",   64'({alu_a, alu_b}), 64'({a[31:16], b[31:16]}));
                chk("hi_cin",  64'(alu_cin), 64'((op == 4'd0) ? lo_c : 1'b0));
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(e[33] ? 1 : (w ? 3 : 2)));
        chk("done_core_idle", 64'({alu_out_en, alu_ctrl, alu_cin, alu_a, alu_b}), 64'd0);
        chk("result",  64'(out_result), 64'(e[31:0]));
        chk("cout",    64'(out_cout), 64'(e[32]));
        chk("tag",     64'(out_tag), 64'(tag));
        chk("illegal", 64'(out_illegal), 64'(e[33]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_state", 64'({out_valid, in_ready, out_tag, out_result}),
                64'({1'b1, 1'b0, tag, e[31:0]}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = 4'h0; in_wide = 1'b0; in_a = 32'h0;
        in_b = 32'h0; in_cin = 1'b0; in_tag = 4'h0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", 64'({out_valid, out_result, out_cout, out_tag, out_illegal}), 64'd0);
        chk("rst_core", 64'({alu_out_en, alu_ctrl, alu_cin, alu_a, alu_b}), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;

        run_req(4'd0, 1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0, 4'h1, 0);
        run_req(4'd0, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 4'h2, 0);
        run_req(4'd2, 1'b1, 32'hF0F0_1234, 32'hFF00_00FF, 1'b0, 4'h3, 0);
        run_req(4'hC, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 4'h5, 0);
        run_req(4'd1, 1'b1, 32'h1234_5678, 32'h0000_0001, 1'b1, 4'h5, 0);
        run_req(4'd1, 1'b0, 32'h0000_0005, 32'h0000_0007, 1'b1, 4'h6, 0);
        run_req(4'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'h7, 5);

        // Reset while the wide ADD is in its HI pass.
        in_valid = 1'b1; in_op = 4'd0; in_wide = 1'b1; in_a = 32'h1111_FFFF;
        in_b = 32'h2222_0001; in_cin = 1'b0; in_tag = 4'h9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_hi", 64'({alu_out_en, alu_a}), 64'({1'b1, 16'h1111}));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_outs", 64'({out_valid, out_result, out_cout, out_tag, out_illegal}), 64'd0);
        chk("midrst_core", 64'({alu_out_en, alu_ctrl, alu_cin, alu_a, alu_b}), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        run_req(4'd4, 1'b0, 32'h0000_AAAA, 32'h0000_0FF0, 1'b0, 4'hA, 1);

        for (int n = 0; n < 40; n++) begin
            run_req(4'($urandom_range(0, 10)), 1'($urandom), $urandom, $urandom,
                    1'($urandom), 4'($urandom), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
